// File: rtl/opll_write_sequencer.sv
// Paces register writes into an OPLL core: address strobe, address settle, data strobe, data settle.
// Build option OPLL_SEQ_ADDR_CACHE_EN skips the address phase when the register index is unchanged.
module opll_write_sequencer #(
   parameter int PULSE_TICKS = 2,
   parameter int ADDR_WAIT   = 12,
   parameter int DATA_WAIT   = 84
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_data,
   output logic       opll_cs_n,
   output logic       opll_wr_n,
   output logic       opll_a0,
   output logic [7:0] opll_d,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_WR,
      S_ADDR_WAIT,
      S_DATA_WR,
      S_DATA_WAIT
   } state_t;

   // Counters hold "ticks remaining minus one", so a zero count with cen set ends the phase.
   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_TICKS - 1);
   localparam logic [7:0] ADDR_LOAD  = 8'(ADDR_WAIT - 1);
   localparam logic [7:0] DATA_LOAD  = 8'(DATA_WAIT - 1);

   state_t     state;
   state_t     next_state;
   logic [7:0] count;
   logic [7:0] next_count;
   logic [7:0] lat_reg;
   logic [7:0] lat_data;
   logic [7:0] next_lat_reg;
   logic [7:0] next_lat_data;
   logic       accept;
   logic       phase_done;
   logic       cache_hit;
   logic       next_cs_n;
   logic       next_wr_n;
   logic       next_a0;
   logic [7:0] next_d;

   assign req_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign accept     = req_valid && req_ready;
   assign phase_done = cen && (count == 8'd0);

`ifdef OPLL_SEQ_ADDR_CACHE_EN
   logic [7:0] last_reg;
   logic       last_valid;

   // The core's address latch is known only once an address strobe has fully completed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg   <= 8'h00;
         last_valid <= 1'b0;
      end else if (state == S_ADDR_WR && phase_done) begin
         last_reg   <= lat_reg;
         last_valid <= 1'b1;
      end
   end

   assign cache_hit = last_valid && (req_reg == last_reg);
`else
   assign cache_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE:      if (accept) next_state = cache_hit ? S_DATA_WR : S_ADDR_WR;
         S_ADDR_WR:   if (phase_done) next_state = S_ADDR_WAIT;
         S_ADDR_WAIT: if (phase_done) next_state = S_DATA_WR;
         S_DATA_WR:   if (phase_done) next_state = S_DATA_WAIT;
         S_DATA_WAIT: if (phase_done) next_state = S_IDLE;
         default:     next_state = S_IDLE;
      endcase
   end

   // Every state change reloads the counter, so no phase can inherit a stale count.
   always_comb begin
      next_count = count;
      if (next_state != state) begin
         unique case (next_state)
            S_ADDR_WR, S_DATA_WR: next_count = PULSE_LOAD;
            S_ADDR_WAIT:          next_count = ADDR_LOAD;
            S_DATA_WAIT:          next_count = DATA_LOAD;
            default:              next_count = 8'd0;
         endcase
      end else if (cen && count != 8'd0) begin
         next_count = count - 8'd1;
      end
   end

   always_comb begin
      next_lat_reg  = lat_reg;
      next_lat_data = lat_data;
      if (accept) begin
         next_lat_reg  = req_reg;
         next_lat_data = req_data;
      end
   end

   // Bus values are decoded from the upcoming state and registered, keeping req_* off any opll_* path.
   always_comb begin
      next_cs_n = 1'b1;
      next_wr_n = 1'b1;
      next_a0   = 1'b0;
      next_d    = 8'h00;
      unique case (next_state)
         S_ADDR_WR: begin
            next_cs_n = 1'b0;
            next_wr_n = 1'b0;
            next_d    = next_lat_reg;
         end
         S_ADDR_WAIT: begin
            next_d = next_lat_reg;
         end
         S_DATA_WR: begin
            next_cs_n = 1'b0;
            next_wr_n = 1'b0;
            next_a0   = 1'b1;
            next_d    = next_lat_data;
         end
         S_DATA_WAIT: begin
            next_a0 = 1'b1;
            next_d  = next_lat_data;
         end
         default: begin
            next_d = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= 8'd0;
         lat_reg   <= 8'h00;
         lat_data  <= 8'h00;
         opll_cs_n <= 1'b1;
         opll_wr_n <= 1'b1;
         opll_a0   <= 1'b0;
         opll_d    <= 8'h00;
      end else begin
         count     <= next_count;
         lat_reg   <= next_lat_reg;
         lat_data  <= next_lat_data;
         opll_cs_n <= next_cs_n;
         opll_wr_n <= next_wr_n;
         opll_a0   <= next_a0;
         opll_d    <= next_d;
      end
   end

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Bench for opll_write_sequencer: directed latency cases plus random cen/requests checked each cycle
// against a phase/tick model of the write protocol.
module tb_opll_write_sequencer;

   localparam int PULSE = 2;
   localparam int AW    = 12;
   localparam int DW    = 84;
`ifdef OPLL_SEQ_ADDR_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cen;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_reg;
   logic [7:0] req_data;
   logic       opll_cs_n;
   logic       opll_wr_n;
   logic       opll_a0;
   logic [7:0] opll_d;
   logic       busy;

   opll_write_sequencer #(
      .PULSE_TICKS(PULSE),
      .ADDR_WAIT(AW),
      .DATA_WAIT(DW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cen(cen),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_reg(req_reg),
      .req_data(req_data),
      .opll_cs_n(opll_cs_n),
      .opll_wr_n(opll_wr_n),
      .opll_a0(opll_a0),
      .opll_d(opll_d),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int edgeCount = 0;

   // Model: phase 0 idle, 1 address strobe, 2 address settle, 3 data strobe, 4 data settle.
   int         ph = 0;
   int         ticksLeft = 0;
   logic [7:0] mReg = 8'h00;
   logic [7:0] mData = 8'h00;
   logic [7:0] cReg = 8'h00;
   bit         cValid = 1'b0;
   bit         acceptedNow = 1'b0;

   function automatic int dur(input int p);
      case (p)
         1, 3:    return PULSE;
         2:       return AW;
         4:       return DW;
         default: return 0;
      endcase
   endfunction

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b at edge %0d", tag, obs, exp, edgeCount);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h at edge %0d", tag, obs, exp, edgeCount);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelEdge(input bit c);
      acceptedNow = 1'b0;
      if (ph == 0) begin
         if (req_valid) begin
            mReg        = req_reg;
            mData       = req_data;
            acceptedNow = 1'b1;
            ph          = (CACHE && cValid && req_reg == cReg) ? 3 : 1;
            ticksLeft   = dur(ph);
         end
      end else if (c) begin
         ticksLeft--;
         if (ticksLeft == 0) begin
            if (ph == 1) begin
               cValid = 1'b1;
               cReg   = mReg;
            end
            ph        = (ph == 4) ? 0 : ph + 1;
            ticksLeft = dur(ph);
         end
      end
   endtask

   task automatic modelReset();
      ph        = 0;
      ticksLeft = 0;
      mReg      = 8'h00;
      mData     = 8'h00;
      cValid    = 1'b0;
   endtask

   task automatic checkOutput();
      logic [7:0] expD;
      expD = (ph == 0) ? 8'h00 : ((ph <= 2) ? mReg : mData);
      checkBit("req_ready", req_ready, ph == 0);
      checkBit("busy", busy, ph != 0);
      checkBit("opll_cs_n", opll_cs_n, !(ph == 1 || ph == 3));
      checkBit("opll_wr_n", opll_wr_n, !(ph == 1 || ph == 3));
      checkBit("opll_a0", opll_a0, ph >= 3);
      check8("opll_d", opll_d, expD);
   endtask

   // Issues one request and runs until the sequencer reports ready again (or abortAt cycles elapse).
   // period 0 means random cen; otherwise cen pulses once every period edges after the accept.
   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d, input int period,
                                input bit hold, input int abortAt,
                                output int acceptEdge, output int readyEdge);
      bit c;
      req_reg    = r;
      req_data   = d;
      req_valid  = 1'b1;
      acceptEdge = -1;
      readyEdge  = -1;
      for (int i = 0; i < 5000; i++) begin
         if (acceptEdge < 0) c = 1'b1;
         else if (period == 0) c = 1'($urandom_range(0, 1));
         else c = ((edgeCount + 1 - acceptEdge) % period) == 0;
         cen = c;
         @(posedge clk);
         edgeCount++;
         modelEdge(c);
         #1;
         if (acceptedNow && acceptEdge < 0) begin
            acceptEdge = edgeCount;
            if (!hold) begin
               req_valid = 1'b0;
               req_reg   = 8'($urandom);
               req_data  = 8'($urandom);
            end
         end
         checkOutput();
         if (abortAt > 0 && acceptEdge >= 0 && edgeCount == acceptEdge + abortAt) return;
         if (acceptEdge >= 0 && edgeCount > acceptEdge && req_ready) begin
            readyEdge = edgeCount;
            return;
         end
      end
      checkBit("write_timeout", 1'b0, 1'b1);
   endtask

   int a1, r1, a2, r2;

   initial begin
      rst_n     = 1'b0;
      cen       = 1'b0;
      req_valid = 1'b0;
      req_reg   = 8'h00;
      req_data  = 8'h00;
      repeat (3) @(posedge clk);
      edgeCount += 3;
      #1;
      modelReset();
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] basic write, cen always high");
      applyStimulus(8'h10, 8'h55, 1, 1'b0, 0, a1, r1);
      checkInt("latency_basic", r1 - a1, 100);

      $display("[TB] same write, cen 1-in-4");
      applyStimulus(8'h10, 8'h55, 4, 1'b0, 0, a1, r1);
      checkInt("latency_cen4", r1 - a1, CACHE ? 344 : 400);

      $display("[TB] back-to-back with req_valid held");
      applyStimulus(8'h30, 8'hA1, 1, 1'b1, 0, a1, r1);
      applyStimulus(8'h31, 8'hA2, 1, 1'b0, 0, a2, r2);
      checkInt("b2b_second_accept", a2 - a1, 101);

      $display("[TB] repeated register index");
      applyStimulus(8'h20, 8'h01, 1, 1'b0, 0, a1, r1);
      checkInt("latency_first_20", r1 - a1, 100);
      applyStimulus(8'h20, 8'h02, 1, 1'b0, 0, a2, r2);
      checkInt("latency_second_20", r2 - a2, CACHE ? 86 : 100);

      $display("[TB] reset during data settle");
      applyStimulus(8'h20, 8'h03, 1, 1'b0, 50, a1, r1);
      checkInt("abort_in_data_wait", ph, 4);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkBit("rst_cs_n", opll_cs_n, 1'b1);
      checkBit("rst_wr_n", opll_wr_n, 1'b1);
      checkBit("rst_busy", busy, 1'b0);
      checkOutput();
      repeat (2) @(posedge clk);
      edgeCount += 2;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput();
      applyStimulus(8'h20, 8'h04, 1, 1'b0, 0, a1, r1);
      checkInt("latency_after_reset", r1 - a1, 100);

      $display("[TB] random requests with random cen");
      for (int k = 0; k < 6; k++) begin
         applyStimulus(8'(8'h40 + $urandom_range(0, 2)), 8'($urandom), 0, 1'b0, 0, a1, r1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/opll_write_sequencer.md
OPLL_WRITE_SEQUENCER -- requirements
Module: opll_write_sequencer

Interface
REQ-001 Parameter PULSE_TICKS, default 2: WR_n low width, in cen ticks, for each bus write (legal range 1..255).
REQ-002 Parameter ADDR_WAIT, default 12: idle ticks after the address write (legal range 1..255).
REQ-003 Parameter DATA_WAIT, default 84: idle ticks after the data write (legal range 1..255).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cen  input  1  OPLL master-clock tick enable; all counters advance only when cen=1.
REQ-007 req_valid  input  1  write request present.
REQ-008 req_ready  output  1  sequencer can accept a request.
REQ-009 req_reg  input  8  OPLL register index.
REQ-010 req_data  input  8  value to write.
REQ-011 opll_cs_n  output  1  chip select to OPLL core, active low.
REQ-012 opll_wr_n  output  1  write strobe to OPLL core, active low.
REQ-013 opll_a0  output  1  0 = address cycle, 1 = data cycle.
REQ-014 opll_d  output  8  bus data to OPLL core.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ADDR_WR, ADDR_WAIT, DATA_WR, DATA_WAIT.
REQ-017 req_ready SHALL equal 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1; req_reg and req_data are latched at that edge.
REQ-018 Accept SHALL move IDLE->ADDR_WR on the same edge, regardless of cen.
REQ-019 Each timed state SHALL load an 8-bit down-counter with its duration minus 1 on entry, decrement on cen=1, and exit on the edge where counter=0 and cen=1; each state thus spans exactly its duration in cen ticks.
REQ-020 ADDR_WR: cs_n=0, wr_n=0, a0=0, d=latched reg; duration PULSE_TICKS; next ADDR_WAIT.
REQ-021 ADDR_WAIT: cs_n=1, wr_n=1, a0=0, d=latched reg; duration ADDR_WAIT; next DATA_WR.
REQ-022 DATA_WR: cs_n=0, wr_n=0, a0=1, d=latched data; duration PULSE_TICKS; next DATA_WAIT.
REQ-023 DATA_WAIT: cs_n=1, wr_n=1, a0=1, d=latched data; duration DATA_WAIT; next IDLE.
REQ-024 IDLE: cs_n=1, wr_n=1, a0=0, d=8'h00.
REQ-025 All bus outputs SHALL be registered (no combinational path from req_* to opll_*).
REQ-026 req_valid deasserting or req_* changing after accept SHALL have no effect on the in-flight write.
REQ-027 cen=0 for any span SHALL freeze state, counter, and outputs.
REQ-028 A request arriving while busy SHALL be held off by req_ready=0; it is accepted on the first edge back in IDLE (no idle bubble beyond that edge).

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, counter=0, cs_n=1, wr_n=1, a0=0, d=8'h00, req_ready=1 after release, busy=0, and clear any latched request, including mid-write (the partial write is abandoned).

Configuration
REQ-030 Macro OPLL_SEQ_ADDR_CACHE_EN defined: the module keeps last_reg plus a valid flag, set when an ADDR_WR completes; an accepted request whose req_reg equals last_reg with valid=1 SHALL go IDLE->DATA_WR, skipping ADDR_WR and ADDR_WAIT; reset clears valid.
REQ-031 Macro undefined: every request SHALL perform the full address phase; no cache storage is present.

Verification
REQ-032 cen=1, defaults, write reg 8'h10 data 8'h55 -> wr_n low 2 cycles with a0=0 d=10, 12 idle cycles, wr_n low 2 cycles with a0=1 d=55, req_ready high again exactly 100 cycles after accept.
REQ-033 cen pulsing 1-in-4, same write -> each phase lasts 4x its cycle count; req_ready returns 400 cycles after accept.
REQ-034 Two back-to-back requests, req_valid held -> second accepted on the edge IDLE is reached; second address strobe begins 101 cycles after the first accept.
REQ-035 rst_n low during DATA_WAIT -> cs_n=1, wr_n=1, busy=0 asynchronously; next write begins with a full address phase.
REQ-036 With OPLL_SEQ_ADDR_CACHE_EN, write reg 8'h20 twice -> second write shows no a0=0 strobe and completes 86 cycles after accept; without the macro -> 100 cycles.
